seq_change_monitor: RTL
=======================

Name: seq_change_monitor

Overview:
- Synthesisable, clocked counterpart to `$monitor`.
- Sits directly downstream of a combinational/continuous-assignment network (e.g. a small a/b/c net) and samples its settled value once per clock edge.
- Each sampled value that differs from the previous sample is pushed into an event FIFO, drained through a valid/ready handshake.
- Gives benches a cycle-accurate, simulator-independent record of when the upstream net settles, unaffected by intra-timestep process interleaving.

Parameters:
- W, 3, width of sampled bus.
- DEPTH, 4, event FIFO depth; power of two, ≥2.
- TSW, 8, timestamp counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_i  in  W  upstream net value, sampled at each rising edge.
- evt_valid_o  out  1  head-of-FIFO event available.
- evt_ready_i  in  1  consumer accepts head event.
- evt_data_o  out  W (W+TSW with feature)  head event payload.
- overflow_o  out  1  sticky: at least one event was dropped.
- drop_cnt_o  out  8  dropped-event count, saturating at 255.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: rst high at an edge sets all of the following:
  - evt_valid_o=0, overflow_o=0, drop_cnt_o=0, level_o=0, evt_data_o=0.
  - FIFO pointers=0, prev register=0, armed=0, timestamp=0.
  - Reset mid-operation discards all queued events immediately (same edge).
- Change detect, at each edge with rst low:
  - change = !armed OR (sample_i !== prev).
  - The first post-reset edge always produces an event, mirroring `$monitor`'s initial print.
  - A sample containing X/Z bits counts as a change in simulation (case inequality); the synthesised logic is identical to `!=`.
  - prev <= sample_i; armed <= 1.
- Push: on change, the payload is written at the tail.
  - Latency: a sample taken at edge k appears on evt_data_o with evt_valid_o=1 after edge k. The earliest observation is in cycle k+1; there is no combinational bypass.
- Pop: a transfer occurs when evt_valid_o && evt_ready_i at an edge; the head advances.
  - evt_data_o is held stable while valid and not ready.
- evt_valid_o = (level != 0); evt_data_o is driven from a registered head.
- Full, push without pop: the event is dropped; overflow_o <= 1; drop_cnt_o increments, saturating at 255. FIFO contents are unchanged.
- Full, push with pop in the same edge: the pop frees a slot, the push is accepted, and level is unchanged. No drop.
- Empty, push only: level 0->1. Pop with no push: level decrements.
- Pointers wrap modulo DEPTH. level_o ranges 0..DEPTH.
- overflow_o and drop_cnt_o are cleared only by rst.
- No internal state machine beyond armed (IDLE -> ARMED on the first post-reset edge; ARMED until rst).

Optional Feature:
- Macro: SEQ_CHANGE_MONITOR_TIMESTAMP_EN.
- Defined:
  - A TSW-bit cycle counter increments every non-reset edge and wraps silently at 2^TSW-1 -> 0.
  - It is 0 on the first post-reset edge.
  - evt_data_o = {timestamp_at_sample, sample}; width W+TSW.
- Undefined: no counter is instantiated; evt_data_o is W bits of sample only.

Test Plan:
1. Reset release, then sample_i held 3'b111 for 5 edges with ready=1 -> exactly one event, 3'b111 (timestamp 0 if enabled), valid for 1 cycle; level_o returns to 0.
2. sample_i sequence 000,001,001,011,011 with ready=1 -> events 000,001,011, at timestamps 0,1,3 when enabled.
3. ready=0, sample_i toggles 0/1 for 7 edges with DEPTH=4 -> level_o=4, overflow_o=1, drop_cnt_o=3; then ready=1 -> drains the first 4 values in order.
4. FIFO full, ready=1 and a new change in the same edge -> no drop, level stays 4, drop_cnt_o unchanged.
5. Assert rst for 1 edge with level=3 -> next cycle evt_valid_o=0, level_o=0, overflow_o=0; the next non-reset edge produces an event even if sample_i is unchanged.
6. sample_i driven 3'bx11 then 3'b111 -> two events (X counted as a change). With feature enabled, counter preloaded near 2^TSW-1 -> timestamps wrap from 255 to 0 with TSW=8.

Source files
------------

// File: rtl/seq_change_monitor.sv
// seq_change_monitor: clocked change monitor that queues every sampled value differing from the previous one.
// Define SEQ_CHANGE_MONITOR_TIMESTAMP_EN to prefix each event with a TSW-bit cycle timestamp.
module seq_change_monitor #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    parameter int TSW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             sample_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
`ifdef SEQ_CHANGE_MONITOR_TIMESTAMP_EN
    output logic [W+TSW-1:0]         evt_data_o,
`else
    output logic [W-1:0]             evt_data_o,
`endif
    output logic                     overflow_o,
    output logic [7:0]               drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
`ifdef SEQ_CHANGE_MONITOR_TIMESTAMP_EN
    localparam int DW = W + TSW;
`else
    localparam int DW = W;
`endif
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [W-1:0]  prev;
    logic          armed;
    logic          change, pop, full, accept, drop;
    logic [DW-1:0] payload;
`ifdef SEQ_CHANGE_MONITOR_TIMESTAMP_EN
    logic [TSW-1:0] ts;
    assign payload = {ts, sample_i};
    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + TSW'(1);
    end
`else
    assign payload = sample_i;
`endif
    // Case inequality lets X/Z samples register as changes in simulation.
    assign change = !armed || (sample_i !== prev);
    assign full   = level == (AW+1)'(DEPTH);
    assign pop    = evt_valid_o && evt_ready_i;
    assign accept = change && (!full || pop);
    assign drop   = change && full && !pop;
    assign evt_valid_o = level != '0;
    assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;
    assign level_o     = level;
    always_ff @(posedge clk) begin
        if (accept && !rst) mem[wr_ptr] <= payload;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            prev       <= '0;
            armed      <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            prev  <= sample_i;
            armed <= 1'b1;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(accept) - (AW+1)'(pop);
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 8'hff) drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end
endmodule
